// File: rtl/serial_word_tx_pkg.sv
// Shared definitions for the serial word transmitter: FSM state encoding,
// default frame geometry and a counter-width helper.
package serial_word_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    localparam int SER_DATA_W       = 8;
    localparam int SER_CLKS_PER_BIT = 4;

    // A one-clock bit period still needs a 1-bit counter to exist.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_word_tx_if.sv
// Handshake and line signals between a control FSM (master) and the
// serial word transmitter (slave).
interface serial_word_tx_if
    import serial_word_tx_pkg::*;
#(
    parameter int DATA_W = SER_DATA_W
);
    // send/ready: a word moves on the rising edge where send & ready are both 1;
    // send while ready=0 is dropped, never queued, and data_in matters only on that edge.
    logic [DATA_W-1:0] data_in;
    logic              send;
    logic              ready;
    logic              busy;
    logic              tx;
    logic              done;
    tx_state_e         state;

    modport master (
        output data_in,
        output send,
        input  ready,
        input  busy,
        input  tx,
        input  done,
        input  state
    );

    modport slave (
        input  data_in,
        input  send,
        output ready,
        output busy,
        output tx,
        output done,
        output state
    );

endinterface

// File: rtl/serial_word_tx_bit_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module bit_tick_gen
    import serial_word_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = SER_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int             CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-in/serial-out frame transmitter: start bit, DATA_W data bits LSB first,
// stop bit, each held CLKS_PER_BIT clocks on a registered line.
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int DATA_W       = SER_DATA_W,
    parameter int CLKS_PER_BIT = SER_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst,
    serial_word_tx_if.slave  bus
);

    localparam int               IDX_W    = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [IDX_W-1:0]  idx;
    logic              tx_q;
    logic              ready_q;
    logic              done_q;
    logic              tick;
    logic              tick_clr;

    // Holding the timer clear while idle makes the start bit full length.
    assign tick_clr   = (state == S_IDLE);
    assign shreg_next = shreg >> 1;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            idx     <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.send) begin
                        shreg   <= bus.data_in;
                        idx     <= '0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        idx   <= '0;
                        tx_q  <= shreg[0];
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    // The next level is taken from the shifted value so tx never lags a bit.
                    if (tick) begin
                        shreg <= shreg_next;
                        if (idx == LAST_IDX) begin
                            tx_q  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            idx  <= idx + 1'b1;
                            tx_q <= shreg_next[0];
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = ~ready_q;
    assign bus.tx    = tx_q;
    assign bus.done  = done_q;
    assign bus.state = state;

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: a frame-level reference model expands each
// word into per-cycle {tx, ready, busy, done} expectations compared on the falling edge.
module tb_serial_word_tx;
    import serial_word_tx_pkg::*;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int W1 = 1;
    localparam int C1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_word_tx_if #(.DATA_W(W))  bus ();
    serial_word_tx_if #(.DATA_W(W1)) bus1 ();

    serial_word_tx #(.DATA_W(W), .CLKS_PER_BIT(C)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    serial_word_tx #(.DATA_W(W1), .CLKS_PER_BIT(C1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    int         total = 0;
    int         bad = 0;
    int         sel = 0;
    int         cyc = 0;
    int         done_seen = 0;
    logic [3:0] exp_q[$];
    int         trace_tx[$];

    function automatic logic [3:0] observe(input int s);
        if (s == 0) return {bus.tx, bus.ready, bus.busy, bus.done};
        return {bus1.tx, bus1.ready, bus1.busy, bus1.done};
    endfunction

    // One frame: start 0, data LSB first, stop 1, each level c cycles, then the done cycle.
    function automatic void push_frame(input logic [31:0] word, input int w, input int c);
        logic lvl;
        for (int b = 0; b < w + 2; b++) begin
            if (b == 0) lvl = 1'b0;
            else if (b == w + 1) lvl = 1'b1;
            else lvl = word[b-1];
            for (int k = 0; k < c; k++) exp_q.push_back({lvl, 1'b0, 1'b1, 1'b0});
        end
        exp_q.push_back(4'b1101);
    endfunction

    function automatic void push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(4'b1100);
    endfunction

    task automatic check_v(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_i(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one cycle and compare against the next expected entry.
    task automatic step(input string tag);
        logic [3:0] got;
        logic [3:0] exp;
        @(negedge clk);
        cyc++;
        got = observe(sel);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        trace_tx.push_back(int'(got[3]));
        done_seen += int'(got[0]);
        check_v(tag, got, exp);
    endtask

    task automatic run(input string tag);
        while (exp_q.size() > 0) step(tag);
    endtask

    task automatic launch(input logic [31:0] word, input bit hold);
        if (sel == 0) begin
            bus.data_in = word[W-1:0];
            bus.send    = 1'b1;
        end else begin
            bus1.data_in = word[W1-1:0];
            bus1.send    = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.send  = 1'b0;
            bus1.send = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] word;
        int          first_hi;
        int          run_len;
        int          gap;

        bus.send     = 1'b0;
        bus.data_in  = '0;
        bus1.send    = 1'b0;
        bus1.data_in = '0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check_v("reset_outputs", observe(0), 4'b1100);
        check_v("reset_outputs_edge_dut", observe(1), 4'b1100);
        check_i("reset_state", int'(bus.state), int'(S_IDLE));
        #1 rst = 1'b0;

        push_idle(3);
        run("idle_after_reset");

        // 8'hA5 frame with an ignored FF request injected while busy.
        done_seen = 0;
        launch(32'hA5, 1'b0);
        push_frame(32'hA5, W, C);
        for (int k = 0; k <= 40; k++) begin
            step("frame_a5");
            if (k == 10) begin
                bus.data_in = 8'hFF;
                bus.send    = 1'b1;
            end
            if (k == 11) bus.send = 1'b0;
        end
        push_idle(12);
        run("no_second_frame");
        check_i("a5_done_count", done_seen, 1);

        // Back-to-back: send held, 00 captured then FF; data change after capture ignored.
        trace_tx.delete();
        done_seen = 0;
        launch(32'h00, 1'b1);
        bus.data_in = 8'hFF;
        push_frame(32'h00, W, C);
        push_frame(32'hFF, W, C);
        for (int k = 0; k < 82; k++) begin
            step("back_to_back");
            if (k == 41) bus.send = 1'b0;
        end
        check_i("b2b_done_count", done_seen, 2);
        first_hi = -1;
        for (int i = 0; i < trace_tx.size(); i++) begin
            if (first_hi < 0 && trace_tx[i] == 1) first_hi = i;
        end
        run_len = 0;
        if (first_hi >= 0) begin
            for (int i = first_hi; i < trace_tx.size() && trace_tx[i] == 1; i++) run_len++;
        end
        check_i("b2b_high_gap", run_len, C + 1);
        push_idle(4);
        run("idle_after_b2b");

        // Random words with random idle gaps (gap 0 is a back-to-back capture).
        for (int r = 0; r < 6; r++) begin
            gap = $urandom_range(0, 3);
            push_idle(gap);
            run("random_gap");
            word = $urandom;
            launch(word, 1'b0);
            push_frame(word, W, C);
            run("random_frame");
        end
        push_idle(2);
        run("idle_after_random");

        // Reset pulse during data bit 3 of a random frame.
        word = $urandom;
        launch(word, 1'b0);
        push_frame(word, W, C);
        for (int k = 0; k < 18; k++) step("pre_reset_frame");
        #1 rst = 1'b1;
        #1;
        check_v("midframe_reset_outputs", observe(0), 4'b1100);
        check_i("midframe_reset_state", int'(bus.state), int'(S_IDLE));
        #1 rst = 1'b0;
        exp_q.delete();
        push_idle(3);
        run("idle_after_midframe_reset");
        launch(32'h3C, 1'b0);
        push_frame(32'h3C, W, C);
        push_idle(4);
        run("frame_3c_after_reset");

        // One-bit words at one clock per bit.
        sel = 1;
        done_seen = 0;
        launch(32'h0, 1'b0);
        push_frame(32'h0, W1, C1);
        push_idle(2);
        run("edge_frame_0");
        check_i("edge_done_count", done_seen, 1);
        word = $urandom_range(0, 1);
        launch(word, 1'b1);
        push_frame(word, W1, C1);
        word = $urandom_range(0, 1);
        bus1.data_in = word[0];
        push_frame(word, W1, C1);
        for (int k = 0; k < 8; k++) begin
            step("edge_back_to_back");
            if (k == 4) bus1.send = 1'b0;
        end
        push_idle(3);
        run("edge_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
